// File: rtl/ram_arb_pkg.sv
// Shared state encoding, port ids and limits for ram_arbiter.
// Imported by ram_arb_pick and ram_arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  localparam int MAX_READ_LATENCY = 4;
  localparam int LAT_W = $clog2(MAX_READ_LATENCY);

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for the two RAM requesters.
// RAM_ARB_ROUND_ROBIN_EN: alternate ties via Last_Grant; else port 1 wins ties.
module ram_arb_pick (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Req0,
  input  logic Req1,
  input  logic Grant_En,
  output logic Grant_Valid,
  output logic Grant_Id
);
  import ram_arb_pkg::*;

  assign Grant_Valid = Req0 | Req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    Grant_Id = PORT_DATA;
    unique case (1'b1)
      (Req0 && Req1):  Grant_Id = ~last_grant;
      (Req0 && !Req1): Grant_Id = PORT_IFETCH;
      default:         Grant_Id = PORT_DATA;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      last_grant <= PORT_DATA;
    else if (Grant_En && Grant_Valid)
      last_grant <= Grant_Id;
  end
`else
  logic unused_ok;

  // Data port owns every tie; ifetch only wins when alone.
  assign Grant_Id  = Req1 ? PORT_DATA : PORT_IFETCH;
  assign unused_ok = ^{Clock, Reset_n, Grant_En};
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port RAM (ifetch = port 0, data = port 1).
// Tie-break mode selected by RAM_ARB_ROUND_ROBIN_EN (see ram_arb_pick).
module ram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  Write0,
  input  logic                  Write1,
  input  logic [ADDR_WIDTH-1:0] Address0,
  input  logic [ADDR_WIDTH-1:0] Address1,
  input  logic [DATA_WIDTH-1:0] Write_Data0,
  input  logic [DATA_WIDTH-1:0] Write_Data1,
  output logic                  Ack0,
  output logic                  Ack1,
  output logic [DATA_WIDTH-1:0] Read_Data0,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [ADDR_WIDTH-1:0] Ram_Address,
  output logic [DATA_WIDTH-1:0] Ram_Write_Data,
  output logic                  Ram_Mem_Write,
  input  logic [DATA_WIDTH-1:0] Ram_Read_Data,
  output logic                  Busy
);
  import ram_arb_pkg::*;

  if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_lat
    $error("ram_arbiter: READ_LATENCY must be 1..4");
  end

  state_t state;
  state_t state_nxt;

  logic                  grant_valid;
  logic                  pick_id;
  logic                  grant_id;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [LAT_W-1:0]      lat_cnt;

  ram_arb_pick u_pick (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Req0        (Req0),
    .Req1        (Req1),
    .Grant_En    (state == IDLE),
    .Grant_Valid (grant_valid),
    .Grant_Id    (pick_id)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (grant_valid) state_nxt = ISSUE;
      ISSUE: state_nxt = lat_write ? RESP : WAIT;
      WAIT:  if (lat_cnt == '0) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requester inputs only matter on the grant edge; everything after uses lat_*.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      grant_id   <= PORT_IFETCH;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_cnt    <= '0;
      Read_Data0 <= '0;
      Read_Data1 <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_valid) begin
        grant_id  <= pick_id;
        lat_write <= pick_id ? Write1 : Write0;
        lat_addr  <= pick_id ? Address1 : Address0;
        lat_wdata <= pick_id ? Write_Data1 : Write_Data0;
      end
      if (state == ISSUE)
        lat_cnt <= LAT_W'(READ_LATENCY - 1);
      if (state == WAIT) begin
        if (lat_cnt == '0) begin
          if (grant_id == PORT_DATA)
            Read_Data1 <= Ram_Read_Data;
          else
            Read_Data0 <= Ram_Read_Data;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
    end
  end

  assign Ram_Address    = lat_addr;
  assign Ram_Write_Data = lat_wdata;
  assign Ram_Mem_Write  = (state == ISSUE) && lat_write;
  assign Busy           = (state != IDLE);
  assign Ack0 = (state == RESP) && (grant_id == PORT_IFETCH);
  assign Ack1 = (state == RESP) && (grant_id == PORT_DATA);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: latency-1 instance plus a latency-3 instance.
// Tie order expectation follows RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1, ram_addr;
  logic [DW-1:0] wd0, wd1, rd0, rd1, ram_wd, ram_rd;
  logic          ack0, ack1, ram_we, busy;

  logic          b_req0, b_req1, b_wr0, b_wr1;
  logic [AW-1:0] b_addr0, b_addr1, b_ram_addr;
  logic [DW-1:0] b_wd0, b_wd1, b_rd0, b_rd1, b_ram_wd, b_ram_rd;
  logic          b_ack0, b_ack1, b_ram_we, b_busy;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .Clock(clk), .Reset_n(rst_n),
    .Req0(req0), .Req1(req1), .Write0(wr0), .Write1(wr1),
    .Address0(addr0), .Address1(addr1),
    .Write_Data0(wd0), .Write_Data1(wd1),
    .Ack0(ack0), .Ack1(ack1), .Read_Data0(rd0), .Read_Data1(rd1),
    .Ram_Address(ram_addr), .Ram_Write_Data(ram_wd),
    .Ram_Mem_Write(ram_we), .Ram_Read_Data(ram_rd), .Busy(busy)
  );

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
    .Clock(clk), .Reset_n(rst_n),
    .Req0(b_req0), .Req1(b_req1), .Write0(b_wr0), .Write1(b_wr1),
    .Address0(b_addr0), .Address1(b_addr1),
    .Write_Data0(b_wd0), .Write_Data1(b_wd1),
    .Ack0(b_ack0), .Ack1(b_ack1), .Read_Data0(b_rd0), .Read_Data1(b_rd1),
    .Ram_Address(b_ram_addr), .Ram_Write_Data(b_ram_wd),
    .Ram_Mem_Write(b_ram_we), .Ram_Read_Data(b_ram_rd), .Busy(b_busy)
  );

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] p1, p2, p3;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wd;
    ram_rd <= mem[ram_addr[7:0]];
  end

  always @(posedge clk) begin
    if (b_ram_we) mem3[b_ram_addr[7:0]] <= b_ram_wd;
    p1 <= mem3[b_ram_addr[7:0]];
    p2 <= p1;
    p3 <= p2;
  end
  assign b_ram_rd = p3;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  typedef struct {
    logic          port;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] shadow [256];
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always @(negedge clk) begin
    exp_t e;
    if (ram_we) begin
      wr_cnt++;
      wr_addr = ram_addr;
      wr_data = ram_wd;
    end
    if (rst_n && (ack0 || ack1)) begin
      chk("ack_excl", 32'(ack0 & ack1), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack1), 32'(e.port));
        if (e.rd) chk("rdata", e.port ? rd1 : rd0, e.data);
      end
    end
  end

  task automatic a_txn(logic port, logic w, logic [AW-1:0] a,
                       logic [DW-1:0] d, int exp_lat, bit swap);
    int n = 0;
    int wc;
    exp_t e;
    @(negedge clk);
    if (port) begin
      req1 = 1'b1; wr1 = w; addr1 = a; wd1 = d;
    end else begin
      req0 = 1'b1; wr0 = w; addr0 = a; wd0 = d;
    end
    e.port = port;
    e.rd   = !w;
    e.data = shadow[a[7:0]];
    sb.push_back(e);
    if (w) shadow[a[7:0]] = d;
    wc = wr_cnt;
    @(posedge clk);
    do begin
      @(negedge clk);
      n++;
      if (swap && n == 1) begin
        addr1 = a + 16'h0010;
        wd1   = ~d;
      end
    end while (!(ack0 || ack1) && n < 20);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("wr_count", 32'(wr_cnt - wc), w ? 32'd1 : 32'd0);
    if (w) begin
      chk("wr_addr", 32'(wr_addr), 32'(a));
      chk("wr_data", wr_data, d);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic b_txn(logic w, logic [AW-1:0] a, logic [DW-1:0] d, int exp_lat);
    int n = 0;
    @(negedge clk);
    b_req0 = 1'b1; b_wr0 = w; b_addr0 = a; b_wd0 = d;
    @(posedge clk);
    do begin
      @(negedge clk);
      n++;
    end while (!b_ack0 && n < 20);
    chk("b_latency", 32'(n), 32'(exp_lat));
    chk("b_ack1", 32'(b_ack1), 32'd0);
    if (!w) chk("b_rdata", b_rd0, d);
    b_req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    exp_t e;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    b_req0 = 0; b_req1 = 0; b_wr0 = 0; b_wr1 = 0;
    b_addr0 = '0; b_addr1 = '0; b_wd0 = '0; b_wd1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'({ack0, ack1, busy, ram_we}), 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_raddr", 32'(ram_addr), 32'd0);
    chk("rst_rwd", ram_wd, 32'd0);
    rst_n = 1'b1;

    a_txn(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 2, 1'b0);
    chk("mem10", mem[8'h10], 32'hDEAD_BEEF);
    a_txn(1'b0, 1'b0, 16'h0010, 32'h0, 3, 1'b0);

    b_txn(1'b1, 16'h0020, 32'h1234_5678, 2);
    b_txn(1'b0, 16'h0020, 32'h1234_5678, 5);

    a_txn(1'b1, 1'b1, 16'h0030, 32'h3030_3030, 2, 1'b0);
    a_txn(1'b1, 1'b1, 16'h0001, 32'h0101_0101, 2, 1'b0);
    a_txn(1'b1, 1'b1, 16'h0002, 32'h0202_0202, 2, 1'b0);
    a_txn(1'b0, 1'b0, 16'h0001, 32'h0, 3, 1'b0);

    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0030; wd1 = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    chk("issue_we", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", 32'({ack0, ack1, busy, ram_we}), 32'd0);
    chk("abort_rd0", rd0, 32'd0);
    chk("abort_rd1", rd1, 32'd0);
    chk("abort_raddr", 32'(ram_addr), 32'd0);
    chk("abort_rwd", ram_wd, 32'd0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_mem", mem[8'h30], shadow[8'h30]);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      e.port = (i % 2) == 1;
`else
      e.port = 1'b1;
`endif
      e.rd   = 1'b1;
      e.data = e.port ? shadow[2] : shadow[1];
      sb.push_back(e);
    end
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0002;
    k = 0;
    n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) k++;
    end
    chk("tie_acks", 32'(k), 32'd4);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("tie_idle", 32'(busy), 32'd0);
    chk("tie_drained", 32'(sb.size()), 32'd0);

    a_txn(1'b1, 1'b1, 16'h0040, 32'h1111_2222, 2, 1'b1);
    a_txn(1'b0, 1'b0, 16'h0040, 32'h0, 3, 1'b0);
    @(negedge clk);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
